// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage. It handles the req/ack handshake, stalls the pipeline and aborts misaligned accesses.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-cycle watchdog that raises bus_err.
module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [ADDR_W-1:0] MEM_ALU_out,
  input  logic [DATA_W-1:0] MEM_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] MEM_read_data,
  output logic              misalign_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                misalign_q, misalign_d;
  logic                stall_c;
  logic                access;
  logic                aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
`endif

  assign access  = MEM_MemRead | MEM_MemWrite;
  assign aligned = (MEM_ALU_out[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (aligned) begin
            // A store wins when both strobes are set; the read is dropped.
            req_d   = 1'b1;
            we_d    = MEM_MemWrite;
            addr_d  = MEM_ALU_out;
            wdata_d = MEM_wdata;
            stall_c = 1'b1;
            state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            misalign_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = dmem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // Expiry only applies without an ack, so a coincident ack completes normally.
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      ST_DONE: begin
        // Pipeline advances here; the next instruction is evaluated in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem_stall     = rst_n & stall_c;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign MEM_read_data = rdata_q;
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl. It covers reset, loads, stores, misalignment and back-to-back accesses.
// It also covers the timeout watchdog when MEM_TIMEOUT_EN is defined, and a long wait otherwise.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_ALU_out;
  logic [31:0] MEM_wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] MEM_read_data;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite),
    .MEM_ALU_out(MEM_ALU_out),
    .MEM_wdata(MEM_wdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .MEM_read_data(MEM_read_data),
    .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction to the MEM stage and follows it until the stall drops.
  // The memory acks in WAIT cycle number ack_wait, and 0 means it never acks.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_wait, input logic [31:0] rdata,
                            output int stall_n, output int req_n, output logic stable,
                            output logic [31:0] rd_done, output logic berr_done,
                            output logic berr_other, output logic finished);
    int w;
    stall_n = 0; req_n = 0; stable = 1'b1; rd_done = '0;
    berr_done = 1'b0; berr_other = 1'b0; finished = 1'b0; w = 0;
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_ALU_out = addr; MEM_wdata = wdata;
    for (int c = 0; c < 300 && !finished; c++) begin
      #1;
      if (mem_stall) stall_n++;
      dmem_ack = 1'b0;
      dmem_rdata = 32'hBAD0_BAD0;
      if (dmem_req) begin
        req_n++;
        w++;
        if (dmem_addr !== addr || dmem_we !== wr || (wr && dmem_wdata !== wdata)) stable = 1'b0;
        if (w == ack_wait) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      if (!mem_stall) begin
        finished = 1'b1;
        rd_done = MEM_read_data;
        berr_done = bus_err;
      end else if (bus_err) begin
        berr_other = 1'b1;
      end
      tick();
    end
    dmem_ack = 1'b0;
    MEM_MemRead = 1'b0;
    MEM_MemWrite = 1'b0;
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h ack_wait=%0d stall=%0d req=%0d data=%h berr=%0b",
             rd, wr, addr, wdata, ack_wait, stall_n, req_n, rd_done, berr_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
    MEM_ALU_out = 32'h0000_0010; MEM_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: req=%b stall=%b, required req=0 stall=0", i, dmem_req, mem_stall);
      end
    end
    checks++;
    if (MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 00000000", MEM_read_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: stall=%b req=%b, required stall=1 req=0", mem_stall, dmem_req);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_req: req=%b required 1", dmem_req);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_0001;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || MEM_read_data !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_first_done: stall=%b data=%h, required stall=0 data=00000001", mem_stall, MEM_read_data);
    end
    tick();
    MEM_MemRead = 1'b0;
    $display("txn reset release load addr=00000010 data=%h", MEM_read_data);
  endtask

  task automatic test_load();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 2 || r != 1) begin
      errors++;
      $display("FAIL load_timing: finished=%b stall=%0d req=%0d, required 1/2/1", fin, s, r);
    end
    checks++;
    if (d !== 32'hDEAD_BEEF || !st) begin
      errors++;
      $display("FAIL load_data: data=%h stable=%b, required deadbeef stable=1", d, st);
    end
  endtask

  task automatic test_store();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'h0, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 6 || r != 5) begin
      errors++;
      $display("FAIL store_timing: finished=%b stall=%0d req=%0d, required 1/6/5", fin, s, r);
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL store_stable: addr/we/wdata moved during WAIT (stable=%b) required 1", st);
    end
    checks++;
    if (MEM_read_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_rdata_hold: got %h required deadbeef", MEM_read_data);
    end
  endtask

  task automatic test_misalign();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0, s, r, st, d, bd, bo, fin);
    checks++;
    if (s != 0 || r != 0 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_pulse: stall=%0d req=%0d err=%b, required 0/0/1", s, r, misalign_err);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: err=%b req=%b, required 0/0", misalign_err, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_req[6];
    logic exp_stall[6];
    exp_req   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_ALU_out = 32'h0000_0030; MEM_wdata = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b1;
        MEM_ALU_out = 32'h0000_0034; MEM_wdata = 32'hCAFE_F00D;
      end
      #1;
      checks++;
      if (dmem_req !== exp_req[c] || mem_stall !== exp_stall[c]) begin
        errors++;
        $display("FAIL b2b cycle %0d: req=%b stall=%b, required req=%b stall=%b",
                 c, dmem_req, mem_stall, exp_req[c], exp_stall[c]);
      end
      dmem_ack = dmem_req;
      dmem_rdata = dmem_req ? 32'h1111_2222 : 32'hBAD0_BAD0;
      tick();
      dmem_ack = 1'b0;
    end
    MEM_MemWrite = 1'b0;
    checks++;
    if (MEM_read_data !== 32'h1111_2222) begin
      errors++;
      $display("FAIL b2b_rdata: got %h required 11112222", MEM_read_data);
    end
    $display("txn back-to-back load 00000030 + store 00000034 data=%h", MEM_read_data);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 5 || r != 4) begin
      errors++;
      $display("FAIL timeout_timing: finished=%b stall=%0d req=%0d, required 1/5/4", fin, s, r);
    end
    checks++;
    if (bd !== 1'b1 || bo !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL timeout_buserr: berr_done=%b berr_early=%b data=%h, required 1/0/00000000", bd, bo, d);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_len: bus_err=%b required 0", bus_err);
    end
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4, 32'h5555_AAAA, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 5 || bd !== 1'b0 || bo !== 1'b0 || d !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL timeout_ack_wins: stall=%0d berr=%b/%b data=%h, required 5/0/0/5555aaaa", s, bd, bo, d);
    end
  endtask
`else
  task automatic test_long_wait();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 20, 32'h7777_8888, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 21 || r != 20 || !st) begin
      errors++;
      $display("FAIL long_wait_timing: finished=%b stall=%0d req=%0d stable=%b, required 1/21/20/1", fin, s, r, st);
    end
    checks++;
    if (d !== 32'h7777_8888 || bd !== 1'b0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL long_wait_data: data=%h berr=%b/%b, required 77778888/0/0", d, bd, bo);
    end
  endtask
`endif

  task automatic test_reset_mid_access();
    int s, r; logic st, bd, bo, fin; logic [31:0] d;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_ALU_out = 32'h0000_0050;
    tick();
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_enter_wait: req=%b required 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stall: stall=%b required 0", mem_stall);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0 || MEM_read_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_req_drop: req=%b data=%h, required 0/00000000", dmem_req, MEM_read_data);
    end
    rst_n = 1'b1; MEM_MemRead = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (MEM_read_data !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL midreset_late_ack: data=%h req=%b stall=%b, required 00000000/0/0",
               MEM_read_data, dmem_req, mem_stall);
    end
    $display("txn reset mid-access addr=00000050, late ack ignored data=%h", MEM_read_data);
    run_access(1'b1, 1'b0, 32'h0000_0060, 32'h0, 2, 32'hA5A5_0F0F, s, r, st, d, bd, bo, fin);
    checks++;
    if (!fin || s != 3 || r != 2 || d !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL midreset_recover: stall=%0d req=%0d data=%h, required 3/2/a5a50f0f", s, r, d);
    end
  endtask

  initial begin
    rst_n = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    MEM_ALU_out = '0; MEM_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
